// File: rtl/w0rm_mem_arb_pkg.sv
// Shared types for the W0RM unified-memory arbiter.
// Optional build macro: W0RM_ARB_ROUND_ROBIN_EN.
package w0rm_mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int INST_W = 16;
  localparam int MEM_AW = 10;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_INST,
    GNT_DATA
  } gnt_e;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_e;

  typedef struct packed {
    port_e             port;
    logic              half_sel;
    logic              is_write;
    logic [ADDR_W-1:0] addr;
  } rsp_tag_t;

  typedef struct packed {
    logic              is_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dreq_t;

  function automatic logic [MEM_AW-1:0] word_addr(
    input logic [ADDR_W-1:0] a
  );
    return a[MEM_AW+1:2];
  endfunction

endpackage

// File: rtl/w0rm_mem_arbiter_if.sv
// Requester and RAM-side signal bundle for w0rm_mem_arbiter.
// slave = arbiter side, master = core/RAM side.
interface w0rm_mem_arb_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int INST_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 10
);

  logic                      inst_valid_i;
  logic [ADDR_WIDTH-1:0]     inst_addr_i;
  logic                      inst_busy_o;
  logic                      inst_valid_o;
  logic [INST_WIDTH-1:0]     inst_data_o;
  logic [ADDR_WIDTH-1:0]     inst_addr_o;

  logic                      dmem_valid_i;
  logic                      dmem_read_i;
  logic                      dmem_write_i;
  logic [ADDR_WIDTH-1:0]     dmem_addr_i;
  logic [DATA_WIDTH-1:0]     dmem_data_i;
  logic                      dmem_busy_o;
  logic                      dmem_valid_o;
  logic [DATA_WIDTH-1:0]     dmem_data_o;

  logic                      ram_en_o;
  logic                      ram_we_o;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr_o;
  logic [DATA_WIDTH-1:0]     ram_din_o;
  logic [DATA_WIDTH-1:0]     ram_dout_i;

  modport slave (
    input  inst_valid_i, inst_addr_i,
    output inst_busy_o, inst_valid_o,
    output inst_data_o, inst_addr_o,
    input  dmem_valid_i, dmem_read_i,
    input  dmem_write_i, dmem_addr_i,
    input  dmem_data_i,
    output dmem_busy_o, dmem_valid_o,
    output dmem_data_o,
    output ram_en_o, ram_we_o,
    output ram_addr_o, ram_din_o,
    input  ram_dout_i
  );

  modport master (
    output inst_valid_i, inst_addr_i,
    input  inst_busy_o, inst_valid_o,
    input  inst_data_o, inst_addr_o,
    output dmem_valid_i, dmem_read_i,
    output dmem_write_i, dmem_addr_i,
    output dmem_data_i,
    input  dmem_busy_o, dmem_valid_o,
    input  dmem_data_o,
    input  ram_en_o, ram_we_o,
    input  ram_addr_o, ram_din_o,
    output ram_dout_i
  );

endinterface

// File: rtl/w0rm_arb_req_slot.sv
// One-entry request holding register with capture, clear and full flag.
module w0rm_arb_req_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         capture,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic [W-1:0] dout
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (capture) begin
      full_d = 1'b1;
      data_d = din;
    end else if (clear) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign dout = data_q;

endmodule

// File: rtl/w0rm_mem_arbiter.sv
// Shares one 1-cycle block RAM between W0RM fetch and data ports.
// Build macro W0RM_ARB_ROUND_ROBIN_EN swaps fixed priority for RR.
module w0rm_mem_arbiter
  import w0rm_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_W,
  parameter int DATA_WIDTH     = DATA_W,
  parameter int INST_WIDTH     = INST_W,
  parameter int MEM_ADDR_WIDTH = MEM_AW
) (
  input  logic           core_clk,
  input  logic           reset,
  w0rm_mem_arb_if.slave  bus
);

  logic                  i_full, d_full;
  logic [ADDR_WIDTH-1:0] i_slot, i_cand;
  dreq_t                 d_slot, d_live, d_cand;
  logic                  i_live_v, d_live_v;
  logic                  i_cand_v, d_cand_v;
  logic                  i_cap, i_clr;
  logic                  d_cap, d_clr;
  gnt_e                  gnt;

  logic                      ram_en, ram_we;
  logic [MEM_ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]     ram_din;

  rsp_tag_t              tag_q, tag_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic                  inst_fire, data_fire;
  logic [INST_WIDTH-1:0] idata_q, idata_d;
  logic [ADDR_WIDTH-1:0] iaddr_q, iaddr_d;
  logic [DATA_WIDTH-1:0] ddata_q, ddata_d;

  // A full slot masks the live input, so a pulse while busy is dropped.
  always_comb begin
    i_live_v = bus.inst_valid_i & ~i_full;
    d_live_v = bus.dmem_valid_i & ~d_full
             & (bus.dmem_read_i | bus.dmem_write_i);
    d_live   = '{is_write: bus.dmem_write_i,
                 addr:     bus.dmem_addr_i,
                 wdata:    bus.dmem_data_i};
    i_cand_v = ~reset & (i_full | i_live_v);
    d_cand_v = ~reset & (d_full | d_live_v);
    i_cand   = i_full ? i_slot : bus.inst_addr_i;
    d_cand   = d_full ? d_slot : d_live;
  end

`ifdef W0RM_ARB_ROUND_ROBIN_EN
  port_e rr_q, rr_d;

  always_comb begin
    gnt = GNT_NONE;
    if (i_cand_v && d_cand_v)
      gnt = (rr_q == PORT_DATA) ? GNT_DATA : GNT_INST;
    else if (d_cand_v)
      gnt = GNT_DATA;
    else if (i_cand_v)
      gnt = GNT_INST;
  end

  always_comb begin
    rr_d = rr_q;
    if (i_cand_v && d_cand_v)
      rr_d = (gnt == GNT_INST) ? PORT_DATA : PORT_INST;
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) rr_q <= PORT_INST;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    gnt = GNT_NONE;
    if (d_cand_v)      gnt = GNT_DATA;
    else if (i_cand_v) gnt = GNT_INST;
  end
`endif

  assign i_cap = i_live_v & (gnt != GNT_INST);
  assign i_clr = i_full   & (gnt == GNT_INST);
  assign d_cap = d_live_v & (gnt != GNT_DATA);
  assign d_clr = d_full   & (gnt == GNT_DATA);

  w0rm_arb_req_slot #(.W(ADDR_WIDTH)) u_inst_slot (
    .clk     (core_clk),
    .rst     (reset),
    .capture (i_cap),
    .clear   (i_clr),
    .din     (bus.inst_addr_i),
    .full    (i_full),
    .dout    (i_slot)
  );

  w0rm_arb_req_slot #(.W($bits(dreq_t))) u_data_slot (
    .clk     (core_clk),
    .rst     (reset),
    .capture (d_cap),
    .clear   (d_clr),
    .din     (d_live),
    .full    (d_full),
    .dout    (d_slot)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    rsp_vld_d = 1'b0;
    tag_d     = tag_q;
    case (gnt)
      GNT_INST: begin
        ram_en         = 1'b1;
        ram_addr       = word_addr(i_cand);
        rsp_vld_d      = 1'b1;
        tag_d.port     = PORT_INST;
        tag_d.half_sel = i_cand[1];
        tag_d.is_write = 1'b0;
        tag_d.addr     = i_cand;
      end
      GNT_DATA: begin
        ram_en         = 1'b1;
        ram_we         = d_cand.is_write;
        ram_addr       = word_addr(d_cand.addr);
        ram_din        = d_cand.is_write ? d_cand.wdata : '0;
        rsp_vld_d      = 1'b1;
        tag_d.port     = PORT_DATA;
        tag_d.half_sel = d_cand.addr[1];
        tag_d.is_write = d_cand.is_write;
        tag_d.addr     = d_cand.addr;
      end
      default: ;
    endcase
  end

  // Data outputs pass RAM data on the strobe cycle, else hold.
  always_comb begin
    inst_fire = rsp_vld_q & (tag_q.port == PORT_INST);
    data_fire = rsp_vld_q & (tag_q.port == PORT_DATA);
    idata_d   = idata_q;
    iaddr_d   = iaddr_q;
    ddata_d   = ddata_q;
    if (inst_fire) begin
      idata_d = tag_q.half_sel
              ? bus.ram_dout_i[DATA_WIDTH-1:INST_WIDTH]
              : bus.ram_dout_i[INST_WIDTH-1:0];
      iaddr_d = tag_q.addr;
    end
    if (data_fire)
      ddata_d = tag_q.is_write ? '0 : bus.ram_dout_i;
  end

  always_ff @(posedge core_clk or posedge reset) begin
    if (reset) begin
      tag_q     <= '0;
      rsp_vld_q <= 1'b0;
      idata_q   <= '0;
      iaddr_q   <= '0;
      ddata_q   <= '0;
    end else begin
      tag_q     <= tag_d;
      rsp_vld_q <= rsp_vld_d;
      idata_q   <= idata_d;
      iaddr_q   <= iaddr_d;
      ddata_q   <= ddata_d;
    end
  end

  assign bus.inst_busy_o  = i_full;
  assign bus.dmem_busy_o  = d_full;
  assign bus.inst_valid_o = inst_fire;
  assign bus.inst_data_o  = idata_d;
  assign bus.inst_addr_o  = iaddr_d;
  assign bus.dmem_valid_o = data_fire;
  assign bus.dmem_data_o  = ddata_d;
  assign bus.ram_en_o     = ram_en;
  assign bus.ram_we_o     = ram_we;
  assign bus.ram_addr_o   = ram_addr;
  assign bus.ram_din_o    = ram_din;

endmodule
